// File: rtl/abort_checker.sv
// Run-control and result checker for an abortable upstream event counter.
// Runs the counter for ABORT_AFTER clocks, pulses abort, settles, then judges the final count.
module abort_checker #(
   parameter int          WIDTH         = 32,
   parameter int          ABORT_AFTER   = 5,
   parameter int          SETTLE_CYCLES = 4,
   parameter int unsigned EXPECT        = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             count_valid,
   input  logic [WIDTH-1:0] count_in,
   output logic             abort,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [WIDTH-1:0] final_count,
   output logic [3:0]       late_events
);

   localparam int LAST_EDGE = ABORT_AFTER + SETTLE_CYCLES;
   localparam int CW        = $clog2(LAST_EDGE + 1);

   localparam logic [CW-1:0]    ABORT_AT = CW'(ABORT_AFTER);
   localparam logic [CW-1:0]    DONE_AT  = CW'(LAST_EDGE);
   localparam logic [WIDTH-1:0] EXPECT_W = WIDTH'(EXPECT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cycle;
   logic             r_abort;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic             r_fail;
   logic [WIDTH-1:0] r_final;
   logic [3:0]       r_late;

   logic [CW-1:0]    w_cycle_next;
   logic             w_first_settle;
   logic             w_late_hit;
   logic [3:0]       w_late_next;
   logic             w_pass;

   // The cycle counter counts edges since the start edge, so the first SETTLE cycle is r_cycle==ABORT_AT.
   assign w_cycle_next   = r_cycle + 1'b1;
   assign w_first_settle = (r_state == S_SETTLE) && (r_cycle == ABORT_AT);
   assign w_late_hit     = count_valid && (r_state == S_SETTLE) && !w_first_settle;
   assign w_late_next    = (w_late_hit && (r_late != 4'hF)) ? r_late + 4'd1 : r_late;

   // NOTE: the verdict uses the next late count so a late pulse on the final SETTLE edge still fails the run.
   assign w_pass = (r_final == EXPECT_W) && (w_late_next == 4'd0);

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cycle <= '0;
         r_abort <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_fail  <= 1'b0;
         r_final <= '0;
         r_late  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_cycle <= '0;
                  r_abort <= 1'b0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
                  r_fail  <= 1'b0;
                  r_final <= '0;
                  r_late  <= '0;
               end
            end

            S_RUN: begin
               r_cycle <= w_cycle_next;
               if (count_valid) begin
                  r_final <= count_in;
               end
               if (w_cycle_next == ABORT_AT) begin
                  r_state <= S_SETTLE;
                  r_abort <= 1'b1;
               end
            end

            S_SETTLE: begin
               r_cycle <= w_cycle_next;
               r_abort <= 1'b0;
               r_late  <= w_late_next;
               // The upstream counter may legally update on the same edge it sees abort.
               if (w_first_settle && count_valid) begin
                  r_final <= count_in;
               end
               if (w_cycle_next == DONE_AT) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= w_pass;
                  r_fail  <= !w_pass;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign abort       = r_abort;
   assign busy        = r_busy;
   assign done        = r_done;
   assign pass        = r_pass;
   assign fail        = r_fail;
   assign final_count = r_final;
   assign late_events = r_late;

endmodule

// File: tb/tb_abort_checker.sv
// Bench for abort_checker: directed and random runs on a default instance and a long-settle instance,
// checked edge by edge against a run-level model of the accepting and late windows.
module tb_abort_checker;

   localparam int W     = 32;
   localparam int A     = 5;
   localparam int S_DEF = 4;
   localparam int S_SAT = 32;
   localparam int EXP   = 2;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic         count_valid;
   logic [W-1:0] count_in;

   logic         d_abort, d_busy, d_done, d_pass, d_fail;
   logic [W-1:0] d_final;
   logic [3:0]   d_late;
   logic         s_abort, s_busy, s_done, s_pass, s_fail;
   logic [W-1:0] s_final;
   logic [3:0]   s_late;

   int n_cmp = 0;
   int n_bad = 0;
   bit sel_sat = 1'b0;

   bit           stim_v[64];
   logic [W-1:0] stim_d[64];

   always #5 clock = ~clock;

   abort_checker #(.WIDTH(W), .ABORT_AFTER(A), .SETTLE_CYCLES(S_DEF), .EXPECT(EXP)) dut (
      .clock(clock), .reset(reset), .start(start), .count_valid(count_valid), .count_in(count_in),
      .abort(d_abort), .busy(d_busy), .done(d_done), .pass(d_pass), .fail(d_fail),
      .final_count(d_final), .late_events(d_late)
   );

   abort_checker #(.WIDTH(W), .ABORT_AFTER(A), .SETTLE_CYCLES(S_SAT), .EXPECT(EXP)) dut_sat (
      .clock(clock), .reset(reset), .start(start), .count_valid(count_valid), .count_in(count_in),
      .abort(s_abort), .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail),
      .final_count(s_final), .late_events(s_late)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int settle_len();
      return sel_sat ? S_SAT : S_DEF;
   endfunction

   // Last value accepted from E1 through E(A+1), as seen after edge k.
   function automatic logic [W-1:0] model_final(input int k);
      logic [W-1:0] f = '0;
      for (int j = 1; j <= k && j <= A + 1; j++)
         if (stim_v[j]) f = stim_d[j];
      return f;
   endfunction

   // Pulses sampled at E(A+2)..E(A+S), saturating at 15, as seen after edge k.
   function automatic int model_late(input int k);
      int l = 0;
      for (int j = A + 2; j <= k && j <= A + settle_len(); j++)
         if (stim_v[j]) l++;
      return (l > 15) ? 15 : l;
   endfunction

   task automatic check_outputs(input string tag, input int k);
      int  last;
      bit  verdict;
      bit  exp_done;
      last     = A + settle_len();
      verdict  = (model_final(last) == W'(EXP)) && (model_late(last) == 0);
      exp_done = (k >= last);
      check($sformatf("%s E%0d busy", tag, k),  sel_sat ? s_busy  : d_busy,  64'(k < last));
      check($sformatf("%s E%0d abort", tag, k), sel_sat ? s_abort : d_abort, 64'(k == A));
      check($sformatf("%s E%0d done", tag, k),  sel_sat ? s_done  : d_done,  64'(exp_done));
      check($sformatf("%s E%0d pass", tag, k),  sel_sat ? s_pass  : d_pass,  64'(exp_done && verdict));
      check($sformatf("%s E%0d fail", tag, k),  sel_sat ? s_fail  : d_fail,  64'(exp_done && !verdict));
      check($sformatf("%s E%0d final", tag, k), sel_sat ? s_final : d_final, 64'(model_final(k)));
      check($sformatf("%s E%0d late", tag, k),  sel_sat ? s_late  : d_late,  64'(model_late(k)));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"},  sel_sat ? s_busy  : d_busy,  64'd0);
      check({tag, " abort"}, sel_sat ? s_abort : d_abort, 64'd0);
      check({tag, " done"},  sel_sat ? s_done  : d_done,  64'd0);
      check({tag, " pass"},  sel_sat ? s_pass  : d_pass,  64'd0);
      check({tag, " fail"},  sel_sat ? s_fail  : d_fail,  64'd0);
      check({tag, " final"}, sel_sat ? s_final : d_final, 64'd0);
      check({tag, " late"},  sel_sat ? s_late  : d_late,  64'd0);
   endtask

   task automatic clear_stim();
      for (int i = 0; i < 64; i++) begin
         stim_v[i] = 1'b0;
         stim_d[i] = '0;
      end
   endtask

   task automatic set_pulse(input int edge_idx, input int value);
      stim_v[edge_idx] = 1'b1;
      stim_d[edge_idx] = W'(value);
   endtask

   task automatic rand_stim();
      for (int i = 0; i < 64; i++) begin
         stim_v[i] = ($urandom_range(0, 2) == 0);
         stim_d[i] = W'($urandom_range(0, 3));
      end
   endtask

   // Entered #1 after a rising edge with the selected DUT in IDLE or DONE; runs E0..E(last+2).
   task automatic do_run(input string tag, input bit hold_start);
      int last;
      last        = A + settle_len();
      start       = 1'b1;
      count_valid = stim_v[0];
      count_in    = stim_d[0];
      for (int k = 0; k <= last + 2; k++) begin
         @(posedge clock);
         #1;
         check_outputs(tag, k);
         start       = hold_start && (k + 1 < last);
         count_valid = stim_v[k + 1];
         count_in    = stim_d[k + 1];
      end
      start       = 1'b0;
      count_valid = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      count_valid = 1'b0;
      count_in    = '0;
      repeat (2) @(posedge clock);
      #1;
      check_all_zero("in_reset");
      reset = 1'b0;
      @(posedge clock);
      #1;
      check_all_zero("idle");

      // Well-behaved counter: pulses sampled at E2 and E4, then silent after abort.
      clear_stim();
      set_pulse(2, 1);
      set_pulse(4, 2);
      set_pulse(0, 7);
      do_run("well_behaved", 1'b0);

      // Counter ignores abort: E6 is still accepted, E8 is late.
      clear_stim();
      set_pulse(2, 1);
      set_pulse(4, 2);
      set_pulse(6, 3);
      set_pulse(8, 4);
      do_run("ignores_abort", 1'b0);

      // Update coincident with abort only.
      clear_stim();
      set_pulse(2, 1);
      set_pulse(4, 2);
      set_pulse(6, 3);
      do_run("coincident", 1'b0);

      // Good count but one late pulse on the final SETTLE edge.
      clear_stim();
      set_pulse(3, 2);
      set_pulse(A + S_DEF, 2);
      do_run("late_on_last_edge", 1'b0);

      // Restart from DONE after a failing run, with start held through RUN/SETTLE.
      clear_stim();
      set_pulse(2, 1);
      set_pulse(4, 2);
      set_pulse(A + S_DEF + 1, 9);
      set_pulse(A + S_DEF + 2, 9);
      do_run("hold_start", 1'b1);

      // Reset asserted mid-SETTLE while abort is high; no clock edge before checking.
      clear_stim();
      set_pulse(2, 2);
      start = 1'b1;
      for (int k = 0; k <= A; k++) begin
         @(posedge clock);
         #1;
         check_outputs("pre_reset", k);
         start       = 1'b0;
         count_valid = stim_v[k + 1];
         count_in    = stim_d[k + 1];
      end
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clock);
      reset       = 1'b0;
      count_valid = 1'b0;
      @(posedge clock);
      #1;
      check_all_zero("after_reset");
      clear_stim();
      set_pulse(1, 2);
      do_run("post_reset_run", 1'b0);

      for (int r = 0; r < 20; r++) begin
         rand_stim();
         do_run($sformatf("rand%0d", r), r[0]);
      end

      // Long-settle instance: 20 late pulses saturate the late counter.
      reset = 1'b1;
      #2;
      reset = 1'b0;
      @(posedge clock);
      #1;
      sel_sat = 1'b1;
      check_all_zero("sat_idle");
      clear_stim();
      set_pulse(2, 2);
      for (int j = A + 2; j < A + 22; j++) set_pulse(j, 5);
      do_run("saturate", 1'b0);

      for (int r = 0; r < 3; r++) begin
         rand_stim();
         do_run($sformatf("sat_rand%0d", r), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
